// File: rtl/debounce_pkg.sv
// Shared types and constants for the input debouncer.
//   db_state_t   : per-channel debounce FSM state
//   DEBOUNCE_MIN : smallest legal DEBOUNCE_CYCLES value
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW,
    ST_WAIT_HI,
    ST_HIGH,
    ST_WAIT_LO
  } db_state_t;

  localparam int DEBOUNCE_MIN = 2;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchroniser, counter-based filter and
// registered single-cycle edge strobes.
//   clk   : system clock, rising edge
//   rst_n : async active-low reset
//   btn   : raw asynchronous input, may bounce
//   level : debounced level
//   rise  : one-cycle strobe on accepted 0->1
//   fall  : one-cycle strobe on accepted 1->0
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int                 CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic            s1, s2;
  db_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic            level_nxt, rise_nxt, fall_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= ST_LOW;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  // Counter defaults to 0 so it idles at 0 in stable states and is cleared
  // whenever a bounce sends a WAIT state back to its stable state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    level_nxt = level;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    unique case (state)
      ST_LOW: begin
        if (s2) state_nxt = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (!s2) begin
          state_nxt = ST_LOW;
        end else if (cnt == CNT_MAX) begin
          state_nxt = ST_HIGH;
          level_nxt = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_HIGH: begin
        if (!s2) state_nxt = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (s2) begin
          state_nxt = ST_HIGH;
        end else if (cnt == CNT_MAX) begin
          state_nxt = ST_LOW;
          level_nxt = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = ST_LOW;
    endcase
  end

endmodule

// File: rtl/input_debouncer.sv
// Debounces N_CH raw push-button/switch inputs for the downstream gate
// stage (channel 0 -> operand A, channel 1 -> operand B).
//   clk       : system clock, rising edge
//   rst_n     : async active-low reset
//   btn_in    : raw asynchronous inputs
//   level_out : debounced level per channel
//   rise_out  : one-cycle strobe per channel on accepted 0->1
//   fall_out  : one-cycle strobe per channel on accepted 1->0
// All outputs are registered; no combinational path from btn_in.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int N_CH            = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] rise_out,
  output logic [N_CH-1:0] fall_out
);

  if (DEBOUNCE_CYCLES < DEBOUNCE_MIN) begin : g_bad_cfg
    $error("input_debouncer: DEBOUNCE_CYCLES=%0d below minimum %0d",
           DEBOUNCE_CYCLES, DEBOUNCE_MIN);
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_in[i]),
      .level (level_out[i]),
      .rise  (rise_out[i]),
      .fall  (fall_out[i])
    );
  end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Conditions raw asynchronous push-button/switch inputs before they reach the combinational logic stage (and1 and its siblings).
- Each channel gets a 2-flop synchroniser, a counter-based debounce filter, and single-cycle rise/fall strobes.
- Outputs drive the A/B operand inputs of the downstream gate stage directly.

Parameters:
- N_CH, 2, number of independent input channels (channel 0 feeds A, channel 1 feeds B).
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to accept a new level. Legal minimum is 2; elaborate with $error if smaller.
- CNT_W, $clog2(DEBOUNCE_CYCLES), counter width. Derived; not overridden.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- btn_in  input  N_CH  raw asynchronous inputs; may bounce.
- level_out  output  N_CH  debounced stable level per channel.
- rise_out  output  N_CH  one-cycle strobe when level_out goes 0->1.
- fall_out  output  N_CH  one-cycle strobe when level_out goes 1->0.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, any time, including mid-debounce):
  - Sync flops, counters, level_out, rise_out and fall_out are all 0 immediately.
  - Every channel state is ST_LOW.
  - No strobe is produced on reset assertion or release.
- Synchroniser: btn_in[i] -> s1[i] -> s2[i], all on clk. The FSM uses s2 only.
- Per-channel FSM, states ST_LOW, ST_WAIT_HI, ST_HIGH, ST_WAIT_LO:
  - ST_LOW: s2=1 -> ST_WAIT_HI, cnt=0. Otherwise stay.
  - ST_WAIT_HI, checked in this order:
    - s2=0 -> ST_LOW, cnt=0, no strobe (bounce rejected).
    - cnt==DEBOUNCE_CYCLES-1 -> ST_HIGH, level_out=1, rise_out=1.
    - Otherwise cnt++.
  - ST_HIGH and ST_WAIT_LO mirror ST_LOW and ST_WAIT_HI with polarities swapped. Acceptance sets level_out=0 and fall_out=1.
- Timing:
  - Count edges from the first rising edge that samples the new btn_in value as edge 1.
  - level_out changes and the strobe asserts after edge DEBOUNCE_CYCLES+3 (edge 7 for DEBOUNCE_CYCLES=4).
- Strobes:
  - Registered; high for exactly one cycle; rise_out and fall_out are never both high on the same channel.
  - level_out holds until the next accepted transition.
- Bounce: any s2 sample disagreeing with the candidate level during a WAIT state returns the FSM to the prior stable state and clears cnt. Stable level and outputs are unchanged.
- Input held high across reset release: debounced normally from ST_LOW, so rise_out fires after DEBOUNCE_CYCLES+3 edges.
- Counter never wraps: it saturates by transitioning at DEBOUNCE_CYCLES-1. In stable states it stays at 0.
- Channels are fully independent. Simultaneous transitions on several channels may strobe in the same cycle.
- All outputs come straight from flops; there is no combinational path from btn_in to any output.

Decomposition:
- Package debounce_pkg holds:
  - typedef enum logic [1:0] {ST_LOW, ST_WAIT_HI, ST_HIGH, ST_WAIT_LO} db_state_t.
  - The localparam minimum DEBOUNCE_CYCLES (2).
- Sub-module debounce_channel: one synchroniser, FSM and counter with scalar ports (clk, rst_n, btn, level, rise, fall).
- input_debouncer instantiates N_CH of them in a generate loop.

Test Plan (DEBOUNCE_CYCLES=4, N_CH=2, 10 ns clock):
1. Reset check: assert rst_n=0 with btn_in=2'b11 -> level_out=2'b00, rise_out=fall_out=2'b00 throughout reset. No strobe in the cycle after release.
2. Clean press: btn_in[0] 0->1, held -> level_out[0]=1 after edge 7. rise_out[0]=1 for exactly one cycle. Channel 1 stays 0.
3. Bounce rejection: btn_in[0] toggles 1,0,1,0 on successive cycles, then stays 0 -> level_out[0] stays 0 and no strobe ever. Then hold 1 for 10 cycles -> single rise_out[0] pulse.
4. Release: from level_out=2'b11, drop btn_in[1] -> fall_out[1] pulses once at edge 7 and level_out=2'b01. Downstream and1 Q goes 1 -> 0.
5. Simultaneous: btn_in 2'b00 -> 2'b11 in one cycle -> rise_out=2'b11 in the same single cycle, level_out=2'b11.
6. Mid-debounce reset: assert rst_n=0 asynchronously, between clock edges, during ST_WAIT_HI at cnt=2 -> outputs 0 immediately. Keep btn_in=1 after release -> rise_out pulses at edge 7 counted from release.
